alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle control sequencer for the register-transfer datapath built around the ALU (Y register, Z hi/lo register, HI/LO, bus, register file).
- On a start request it latches a 5-bit ALU opcode and drives the timed control strobes that move operands onto the bus and through the ALU into Z. It then writes the result back to the general-purpose register file or to HI/LO.
- Sits between instruction decode and the datapath; one operation is in flight at a time.

Parameters:
- OPW, 5, opcode width; the opcode occupies op_sel[31:32-OPW].
- MULDIV_WAIT, 2, number of extra execute cycles op_sel is held stable for mul/div before Zin is strobed (0..15).

Ports:
- clock  in  1  rising-edge system clock
- clear  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- opcode  in  OPW  ALU operation code, captured on an accepted start
- busy  out  1  high from the cycle after acceptance through the done cycle
- done  out  1  one-cycle pulse coincident with the final write strobe
- illegal  out  1  one-cycle pulse when an unsupported opcode is accepted
- op_sel  out  32  ALU select: {opcode_q, 27'b0} in execute states, else 0
- Grb, Grc, Gra  out  1  register-select enables for fields rb, rc, ra
- Rout  out  1  selected register drives the bus
- Rin  out  1  selected register loads from the bus
- Yin  out  1  Y register loads from the bus
- Zin  out  1  Z hi/lo loads the ALU result
- Zlowout, Zhighout  out  1  Z low / Z high drives the bus
- LOin, HIin  out  1  LO / HI load from the bus

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE, opcode_q=0, wait counter=0, every output 0. Any operation in flight is abandoned; no partial strobe is completed after reset release.
- Opcodes:
  - binary: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011
  - mul/div: mul 01111, div 10000
  - unary: neg 10001, not 10010
  - all other codes are illegal.
- Accept: start=1 in IDLE at edge k captures opcode into opcode_q. The first strobe state is active in cycle k+1. start is ignored while busy=1, with no queuing.
- Illegal accept: go to ERR for one cycle with illegal=1, busy=1 and no datapath strobes, then IDLE. done is not asserted.
- States and strobes (each is one cycle unless stated; outputs are Moore, decoded from state):
  - IDLE: all outputs 0.
  - LOADY (binary, mul/div): Grb, Rout, Yin. Next state is EXEC.
  - EXEC:
    - binary: Grc, Rout, op_sel, Zin. Next state is WRLO.
    - unary: Grb, Rout, op_sel, Zin. Next state is WRLO. Unary ops enter EXEC directly from IDLE.
  - MDWAIT (mul/div, MULDIV_WAIT cycles, skipped if 0): Grc, Rout, op_sel; Zin=0. Counter counts down to 0, then the next state is MDEXEC.
  - MDEXEC: Grc, Rout, op_sel, Zin. Next state is WRLO.
  - WRLO:
    - non-muldiv: Zlowout, Gra, Rin, done. Next state is IDLE.
    - mul/div: Zlowout, LOin. Next state is WRHI.
  - WRHI: Zhighout, HIin, done. Next state is IDLE.
- Latency, start edge to done cycle:
  - binary: 3 cycles
  - unary: 2 cycles
  - mul/div: 4+MULDIV_WAIT cycles
- Bus exclusivity: at most one of Rout/Zlowout/Zhighout is high in any cycle. At most one of Gra/Grb/Grc is high.
- A back-to-back start is accepted in the cycle after done (IDLE); there is no same-cycle restart in the done cycle.
- op_sel is stable across all EXEC/MDWAIT/MDEXEC cycles of one operation and is 0 in every other state.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode localparams (OP_ADD … OP_NOT)
  - the state encoding
  - the op_sel construction function {opcode, 27'b0}
- The opcode class decode (binary/unary/muldiv/illegal) lives in the package as a function.
- No sub-module is needed; the wait counter is inline.

Test Plan:
- Reset mid-op: assert clear=0 during MDWAIT of a mul -> all outputs 0 immediately. After release, state is IDLE and no HIin/LOin/done occurs.
- add: start with opcode=00011 at edge 0:
  - cycle 1: Grb, Rout, Yin
  - cycle 2: Grc, Rout, Zin, op_sel=0x18000000
  - cycle 3: Zlowout, Gra, Rin, done
  - cycle 4: busy=0
- not: opcode=10010 -> cycle 1: Grb, Rout, Zin, op_sel=0x90000000; cycle 2: Zlowout, Gra, Rin, done. No Yin at any point.
- mul, MULDIV_WAIT=2, opcode=01111:
  - cycle 1: LOADY
  - cycles 2-3: op_sel=0x78000000 with Zin=0
  - cycle 4: Zin
  - cycle 5: Zlowout, LOin
  - cycle 6: Zhighout, HIin, done
  - never Rin
- illegal opcode=00000 -> cycle 1: illegal=1, busy=1, all strobes 0; cycle 2: IDLE, done never pulses.
- start held high during a sub operation (00100) with opcode changed mid-flight to 01111 -> op_sel stays 0x20000000; the second op is accepted only at the IDLE cycle after done.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, state encoding,
// opcode class decode and the per-state control strobe decode.
package alu_ctrl_pkg;

  localparam int unsigned OpcodeW = 5;

  localparam logic [OpcodeW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OpcodeW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OpcodeW-1:0] OP_AND  = 5'b00101;
  localparam logic [OpcodeW-1:0] OP_OR   = 5'b00110;
  localparam logic [OpcodeW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OpcodeW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OpcodeW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OpcodeW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OpcodeW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OpcodeW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OpcodeW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OpcodeW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OpcodeW-1:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    StIdle,
    StLoadY,
    StExec,
    StMdWait,
    StMdExec,
    StWrLo,
    StWrHi,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    ClsIllegal,
    ClsBinary,
    ClsUnary,
    ClsMulDiv
  } op_class_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic illegal;
    logic sel_en;
    logic grb;
    logic grc;
    logic gra;
    logic rout;
    logic rin;
    logic yin;
    logic zin;
    logic zlo;
    logic zhi;
    logic loin;
    logic hiin;
  } ctrl_t;

  function automatic op_class_e op_class(input logic [OpcodeW-1:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        cls = ClsBinary;
      OP_MUL, OP_DIV:                         cls = ClsMulDiv;
      OP_NEG, OP_NOT:                         cls = ClsUnary;
      default:                                cls = ClsIllegal;
    endcase
    return cls;
  endfunction

  function automatic logic [31:0] op_sel_word(input logic [OpcodeW-1:0] op);
    return {op, 27'b0};
  endfunction

  // Moore strobes for a state; the class only matters where paths share a state.
  function automatic ctrl_t ctrl_decode(input state_e st, input op_class_e cls);
    ctrl_t c;
    c      = '0;
    c.busy = (st != StIdle);
    case (st)
      StLoadY: begin
        c.grb  = 1'b1;
        c.rout = 1'b1;
        c.yin  = 1'b1;
      end
      StExec: begin
        c.grb    = (cls == ClsUnary);
        c.grc    = (cls != ClsUnary);
        c.rout   = 1'b1;
        c.sel_en = 1'b1;
        c.zin    = 1'b1;
      end
      StMdWait: begin
        c.grc    = 1'b1;
        c.rout   = 1'b1;
        c.sel_en = 1'b1;
      end
      StMdExec: begin
        c.grc    = 1'b1;
        c.rout   = 1'b1;
        c.sel_en = 1'b1;
        c.zin    = 1'b1;
      end
      StWrLo: begin
        c.zlo = 1'b1;
        if (cls == ClsMulDiv) begin
          c.loin = 1'b1;
        end else begin
          c.gra  = 1'b1;
          c.rin  = 1'b1;
          c.done = 1'b1;
        end
      end
      StWrHi: begin
        c.zhi  = 1'b1;
        c.hiin = 1'b1;
        c.done = 1'b1;
      end
      StErr:   c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer driving the ALU datapath strobes for one
// operation at a time; all strobes come straight from registers.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPW         = 5,
  parameter int unsigned MULDIV_WAIT = 2
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  output logic           busy,
  output logic           done,
  output logic           illegal,
  output logic [31:0]    op_sel,
  output logic           Grb,
  output logic           Grc,
  output logic           Gra,
  output logic           Rout,
  output logic           Rin,
  output logic           Yin,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           LOin,
  output logic           HIin
);

  localparam logic [3:0] WaitInit = (MULDIV_WAIT == 0) ? 4'd0 : 4'(MULDIV_WAIT - 1);

  state_e           state_q, state_d;
  logic [OPW-1:0]   opcode_q, opcode_d;
  logic [3:0]       cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [OpcodeW-1:0] opc_q5, opc_d5;
  op_class_e        cls_q, cls_d;

  assign opc_q5 = OpcodeW'(opcode_q);
  assign opc_d5 = OpcodeW'(opcode_d);
  assign cls_q  = op_class(opc_q5);
  assign cls_d  = op_class(opc_d5);

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          opcode_d = opcode;
          case (op_class(OpcodeW'(opcode)))
            ClsBinary, ClsMulDiv: state_d = StLoadY;
            ClsUnary:             state_d = StExec;
            default:              state_d = StErr;
          endcase
        end
      end
      StLoadY: begin
        if (cls_q != ClsMulDiv) begin
          state_d = StExec;
        end else if (MULDIV_WAIT == 0) begin
          state_d = StMdExec;
        end else begin
          state_d = StMdWait;
          cnt_d   = WaitInit;
        end
      end
      StExec:   state_d = StWrLo;
      StMdWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StMdExec;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StMdExec: state_d = StWrLo;
      StWrLo:   state_d = (cls_q == ClsMulDiv) ? StWrHi : StIdle;
      StWrHi:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Decoding from the next state keeps outputs registered yet Moore-timed.
  assign ctrl_d = ctrl_decode(state_d, cls_d);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      cnt_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;
  assign illegal  = ctrl_q.illegal;
  assign op_sel   = ctrl_q.sel_en ? op_sel_word(opc_q5) : 32'd0;
  assign Grb      = ctrl_q.grb;
  assign Grc      = ctrl_q.grc;
  assign Gra      = ctrl_q.gra;
  assign Rout     = ctrl_q.rout;
  assign Rin      = ctrl_q.rin;
  assign Yin      = ctrl_q.yin;
  assign Zin      = ctrl_q.zin;
  assign Zlowout  = ctrl_q.zlo;
  assign Zhighout = ctrl_q.zhi;
  assign LOin     = ctrl_q.loin;
  assign HIin     = ctrl_q.hiin;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed bench for alu_op_sequencer, checked every cycle
// against a schedule-queue model of the expected strobe sequence.
module tb_alu_op_sequencer;

  localparam int unsigned W = 2;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic        busy, done, illegal;
  logic [31:0] op_sel;
  logic        Grb, Grc, Gra, Rout, Rin, Yin, Zin, Zlowout, Zhighout, LOin, HIin;

  alu_op_sequencer #(.OPW(5), .MULDIV_WAIT(W)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .opcode   (opcode),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .op_sel   (op_sel),
    .Grb      (Grb),
    .Grc      (Grc),
    .Gra      (Gra),
    .Rout     (Rout),
    .Rin      (Rin),
    .Yin      (Yin),
    .Zin      (Zin),
    .Zlowout  (Zlowout),
    .Zhighout (Zhighout),
    .LOin     (LOin),
    .HIin     (HIin)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy, done, illegal;
    logic [31:0] sel;
    logic        grb, grc, gra, rout, rin, yin, zin, zlo, zhi, loin, hiin;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic obs_t dut_obs();
    obs_t o;
    o = {busy, done, illegal, op_sel, Grb, Grc, Gra, Rout, Rin, Yin, Zin,
         Zlowout, Zhighout, LOin, HIin};
    return o;
  endfunction

  // strb order: grb grc gra rout rin yin zin zlo zhi loin hiin
  function automatic obs_t item(input logic [31:0] sel, input logic [10:0] strb,
                                input logic dn, input logic il);
    obs_t o;
    o = {1'b1, dn, il, sel, strb};
    return o;
  endfunction

  task automatic push_op(input logic [4:0] op);
    logic [31:0] s;
    s = {op, 27'b0};
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        exp_q.push_back(item(32'd0, 11'b100_101_00000, 1'b0, 1'b0));
        exp_q.push_back(item(s,     11'b010_100_10000, 1'b0, 1'b0));
        exp_q.push_back(item(32'd0, 11'b001_010_01000, 1'b1, 1'b0));
      end
      5'd17, 5'd18: begin
        exp_q.push_back(item(s,     11'b100_100_10000, 1'b0, 1'b0));
        exp_q.push_back(item(32'd0, 11'b001_010_01000, 1'b1, 1'b0));
      end
      5'd15, 5'd16: begin
        exp_q.push_back(item(32'd0, 11'b100_101_00000, 1'b0, 1'b0));
        for (int i = 0; i < int'(W); i++)
          exp_q.push_back(item(s,   11'b010_100_00000, 1'b0, 1'b0));
        exp_q.push_back(item(s,     11'b010_100_10000, 1'b0, 1'b0));
        exp_q.push_back(item(32'd0, 11'b000_000_01010, 1'b0, 1'b0));
        exp_q.push_back(item(32'd0, 11'b000_000_00101, 1'b1, 1'b0));
      end
      default: exp_q.push_back(item(32'd0, 11'b0, 1'b0, 1'b1));
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, req);
    end
  endtask

  // One clock: drive, advance the model at the edge, compare after the edge.
  task automatic cyc(input logic s, input logic [4:0] op);
    obs_t e;
    @(negedge clock);
    start  = s;
    opcode = op;
    @(posedge clock);
    if (exp_q.size() == 0) begin
      if (s) push_op(op);
    end else begin
      exp_q.delete(0);
    end
    #1;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("cycle", 64'(dut_obs()), 64'(e));
  endtask

  task automatic reset_pulse();
    clear = 1'b0;
    #1;
    check("reset_async", 64'(dut_obs()), 64'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    check("reset_held", 64'(dut_obs()), 64'd0);
    clear = 1'b1;
  endtask

  logic [4:0] legal [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                             5'd15, 5'd16, 5'd17, 5'd18};

  initial begin
    logic [4:0] op;
    clear  = 1'b0;
    start  = 1'b0;
    opcode = 5'd0;
    #2;
    check("reset_state", 64'(dut_obs()), 64'd0);
    @(negedge clock);
    clear = 1'b1;

    // add
    cyc(1'b1, 5'b00011);
    check("add_c1_loady", {Grb, Rout, Yin, Zin}, 4'b1110);
    cyc(1'b0, 5'd0);
    check("add_c2_opsel", op_sel, 32'h1800_0000);
    check("add_c2_strb", {Grc, Rout, Zin, Yin}, 4'b1110);
    cyc(1'b0, 5'd0);
    check("add_c3_wr", {Zlowout, Gra, Rin, done}, 4'b1111);
    cyc(1'b0, 5'd0);
    check("add_c4_idle", busy, 1'b0);

    // not
    cyc(1'b1, 5'b10010);
    check("not_c1_opsel", op_sel, 32'h9000_0000);
    check("not_c1_strb", {Grb, Rout, Zin, Yin}, 4'b1110);
    cyc(1'b0, 5'd0);
    check("not_c2_wr", {Zlowout, Gra, Rin, done, Yin}, 5'b11110);
    cyc(1'b0, 5'd0);

    // mul
    cyc(1'b1, 5'b01111);
    check("mul_c1_loady", {Grb, Rout, Yin}, 3'b111);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 5'd0);
      check("mul_wait_opsel", op_sel, 32'h7800_0000);
      check("mul_wait_nozin", Zin, 1'b0);
    end
    cyc(1'b0, 5'd0);
    check("mul_c4_zin", {Zin, op_sel}, {1'b1, 32'h7800_0000});
    cyc(1'b0, 5'd0);
    check("mul_c5_lo", {Zlowout, LOin, done, Rin}, 4'b1100);
    cyc(1'b0, 5'd0);
    check("mul_c6_hi", {Zhighout, HIin, done, Rin}, 4'b1110);
    cyc(1'b0, 5'd0);

    // illegal
    cyc(1'b1, 5'b00000);
    check("ill_c1", {illegal, busy, done, Rout, Yin, Zin, op_sel}, {6'b110000, 32'd0});
    cyc(1'b0, 5'd0);
    check("ill_c2", {illegal, busy, done}, 3'b000);

    // sub with start held and opcode changed mid-flight
    cyc(1'b1, 5'b00100);
    cyc(1'b1, 5'b01111);
    check("sub_opsel", op_sel, 32'h2000_0000);
    cyc(1'b1, 5'b01111);
    check("sub_done", done, 1'b1);
    cyc(1'b1, 5'b01111);
    check("sub_idle_gap", busy, 1'b0);
    cyc(1'b1, 5'b01111);
    check("second_accept", {busy, Yin}, 2'b11);
    repeat (8) cyc(1'b0, 5'd0);

    // reset during MDWAIT of a mul
    cyc(1'b1, 5'b01111);
    cyc(1'b0, 5'd0);
    check("mdwait_before_rst", {Zin, op_sel}, {1'b0, 32'h7800_0000});
    #2;
    reset_pulse();
    repeat (8) cyc(1'b0, 5'd0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(99) == 0) begin
        @(negedge clock);
        reset_pulse();
      end else begin
        op = ($urandom_range(1) == 1) ? legal[$urandom_range(12)] : 5'($urandom);
        cyc(($urandom_range(9) < 4), op);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
